// File: rtl/decode_ctrl_pipe.sv
// Registered instruction-decode stage: full opcode decode, field extraction and
// illegal-opcode flagging behind a one-entry pipeline register with load-use interlock.
module decode_ctrl_pipe #(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 5,
  parameter int IMM_W    = 17
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               DMwe,
  output logic               Rwe,
  output logic               Rwd,
  output logic               Rdst,
  output logic               ALUinB,
  output logic               is_branch,
  output logic               is_jump,
  output logic               illegal,
  output logic [4:0]         alu_op,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [INSTR_W-1:0] imm
);

  localparam logic [OPCODE_W-1:0] OP_ALU  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_SETX = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_BEX  = OPCODE_W'(22);

  logic [OPCODE_W-1:0] op;
  logic [REG_W-1:0]    f_rd, f_rs, f_rt;
  logic [INSTR_W-1:0]  f_imm;
  logic is_alu, is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_setx, is_bex;
  logic use_a, use_b_rt, use_b_rd;
  logic [4:0] d_alu_op;
  logic held_lw, hazard, xfer_in, xfer_out;

  assign op    = in_instr[INSTR_W-1 -: OPCODE_W];
  assign f_rd  = in_instr[INSTR_W-OPCODE_W-1 -: REG_W];
  assign f_rs  = in_instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
  assign f_rt  = in_instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
  assign f_imm = {{(INSTR_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

  // Opcode flags are mutually exclusive, so an unknown opcode leaves every control at 0.
  assign is_alu  = (op == OP_ALU);
  assign is_j    = (op == OP_J);
  assign is_bne  = (op == OP_BNE);
  assign is_jal  = (op == OP_JAL);
  assign is_jr   = (op == OP_JR);
  assign is_addi = (op == OP_ADDI);
  assign is_blt  = (op == OP_BLT);
  assign is_sw   = (op == OP_SW);
  assign is_lw   = (op == OP_LW);
  assign is_setx = (op == OP_SETX);
  assign is_bex  = (op == OP_BEX);

  assign d_alu_op = is_alu ? in_instr[6:2] : ((is_bne | is_blt) ? 5'b00001 : 5'b00000);

  // Read-port usage of the incoming instruction; an unused port can never match.
  assign use_a    = is_alu | is_addi | is_lw | is_sw | is_bne | is_blt;
  assign use_b_rt = is_alu;
  assign use_b_rd = is_sw | is_bne | is_blt | is_jr;

  assign hazard = out_valid & held_lw & (rd != '0) &
                  ((use_a & (f_rs == rd)) | (use_b_rt & (f_rt == rd)) | (use_b_rd & (f_rd == rd)));

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // the held outputs never change while out_valid is high and out_ready is low.
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      held_lw   <= 1'b0;
      DMwe      <= 1'b0;
      Rwe       <= 1'b0;
      Rwd       <= 1'b0;
      Rdst      <= 1'b0;
      ALUinB    <= 1'b0;
      is_branch <= 1'b0;
      is_jump   <= 1'b0;
      illegal   <= 1'b0;
      alu_op    <= '0;
      rd        <= '0;
      rs        <= '0;
      rt        <= '0;
      imm       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      held_lw   <= is_lw;
      DMwe      <= is_sw;
      Rwe       <= is_alu | is_addi | is_lw | is_jal | is_setx;
      Rwd       <= is_lw;
      Rdst      <= is_sw | is_bne | is_blt | is_jr;
      ALUinB    <= is_addi | is_lw | is_sw;
      is_branch <= is_bne | is_blt;
      is_jump   <= is_j | is_jal | is_jr | is_bex;
      illegal   <= ~(is_alu | is_j | is_bne | is_jal | is_jr | is_addi | is_blt |
                     is_sw | is_lw | is_setx | is_bex);
      alu_op    <= d_alu_op;
      rd        <= f_rd;
      rs        <= f_rs;
      rt        <= f_rt;
      imm       <= f_imm;
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: directed instructions with hand-computed
// decode results, checked by a monitor whenever an output transfer occurs.
module tb_decode_ctrl_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid;
  logic        out_ready = 1'b1;
  logic        DMwe, Rwe, Rwd, Rdst, ALUinB, is_branch, is_jump, illegal;
  logic [4:0]  alu_op, rd, rs, rt;
  logic [31:0] imm;
  logic [59:0] act;

  logic [59:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int waits;

  decode_ctrl_pipe dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .DMwe(DMwe), .Rwe(Rwe), .Rwd(Rwd), .Rdst(Rdst), .ALUinB(ALUinB),
    .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal),
    .alu_op(alu_op), .rd(rd), .rs(rs), .rt(rt), .imm(imm)
  );

  always #5 clock = ~clock;

  assign act = {illegal, is_branch, is_jump, DMwe, Rwe, Rwd, Rdst, ALUinB, alu_op, rd, rs, rt, imm};

  // ctrl bit order: {illegal, is_branch, is_jump, DMwe, Rwe, Rwd, Rdst, ALUinB}
  function automatic logic [59:0] ex(input logic [7:0] c, input logic [4:0] op,
                                     input logic [4:0] d, input logic [4:0] s,
                                     input logic [4:0] t, input logic [31:0] im);
    return {c, op, d, s, t, im};
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] d,
                                      input logic [4:0] s, input logic [16:0] lo);
    return {op, d, s, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Offer one instruction; returns how many cycles in_ready held it off.
  task automatic send(input logic [31:0] instr, input logic [59:0] e, output int w);
    bit done;
    done = 1'b0;
    w = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        done = 1'b1;
      end else begin
        w++;
        if (w > 20) begin
          chk("send_timeout", 64'(w), 64'd0);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every output transfer pops and compares the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", act, 60'd0);
      end else begin
        chk("decode_out", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(act), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // addi r3,r1,-5
    send(32'h28C3FFFB, ex(8'b0000_1001, 5'd0, 5'd3, 5'd1, 5'd31, 32'hFFFFFFFB), waits);
    chk("addi_latency_valid", 64'(out_valid), 64'd1);

    // load-use via readB=rt: one bubble
    send(enc(5'd8, 5'd4, 5'd2, 17'h0), ex(8'b0000_1101, 5'd0, 5'd4, 5'd2, 5'd0, 32'h0), waits);
    chk("lw4_no_stall", 64'(waits), 64'd0);
    send(enc(5'd0, 5'd5, 5'd6, 17'h0400C), ex(8'b0000_1000, 5'd3, 5'd5, 5'd6, 5'd4, 32'h0000400C), waits);
    chk("lw_add_bubble", 64'(waits), 64'd1);
    chk("add_valid_after_bubble", 64'(out_valid), 64'd1);

    // load-use via sw readB=rd
    send(enc(5'd8, 5'd8, 5'd1, 17'h00010), ex(8'b0000_1101, 5'd0, 5'd8, 5'd1, 5'd0, 32'h10), waits);
    send(enc(5'd7, 5'd8, 5'd3, 17'h00004), ex(8'b0001_0011, 5'd0, 5'd8, 5'd3, 5'd0, 32'h4), waits);
    chk("lw_sw_bubble", 64'(waits), 64'd1);

    // load-use via jr readB=rd
    send(enc(5'd8, 5'd6, 5'd0, 17'h0), ex(8'b0000_1101, 5'd0, 5'd6, 5'd0, 5'd0, 32'h0), waits);
    send(enc(5'd4, 5'd6, 5'd0, 17'h0), ex(8'b0010_0010, 5'd0, 5'd6, 5'd0, 5'd0, 32'h0), waits);
    chk("lw_jr_bubble", 64'(waits), 64'd1);

    // r0 never interlocks
    send(enc(5'd8, 5'd0, 5'd2, 17'h0), ex(8'b0000_1101, 5'd0, 5'd0, 5'd2, 5'd0, 32'h0), waits);
    send(enc(5'd0, 5'd7, 5'd0, 17'h0), ex(8'b0000_1000, 5'd0, 5'd7, 5'd0, 5'd0, 32'h0), waits);
    chk("lw_r0_no_bubble", 64'(waits), 64'd0);
    chk("lw_r0_valid_kept", 64'(out_valid), 64'd1);

    // j reads no register, so matching fields must not interlock
    send(enc(5'd8, 5'd3, 5'd1, 17'h0), ex(8'b0000_1101, 5'd0, 5'd3, 5'd1, 5'd0, 32'h0), waits);
    send(enc(5'd1, 5'd3, 5'd3, 17'h03000), ex(8'b0010_0000, 5'd0, 5'd3, 5'd3, 5'd3, 32'h3000), waits);
    chk("lw_j_no_bubble", 64'(waits), 64'd0);

    // backpressure: outputs held, then drain and accept together
    idle(3);
    chk("drained_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    send(enc(5'd3, 5'd10, 5'd0, 17'h00123), ex(8'b0010_1000, 5'd0, 5'd10, 5'd0, 5'd0, 32'h123), waits);
    in_valid = 1'b1;
    in_instr = enc(5'd7, 5'd9, 5'd2, 17'h00008);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold", {out_valid, rd, imm}, {1'b1, 5'd10, 32'h123});
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(ex(8'b0001_0011, 5'd0, 5'd9, 5'd2, 5'd0, 32'h8));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd1);

    // remaining opcodes, streamed
    send(enc(5'd2, 5'd4, 5'd5, 17'h1FFFE), ex(8'b0100_0010, 5'd1, 5'd4, 5'd5, 5'd31, 32'hFFFFFFFE), waits);
    chk("stream_no_stall", 64'(waits), 64'd0);
    send(enc(5'd6, 5'd1, 5'd2, 17'h00001), ex(8'b0100_0010, 5'd1, 5'd1, 5'd2, 5'd0, 32'h1), waits);
    send(enc(5'd21, 5'd0, 5'd0, 17'h00010), ex(8'b0000_1000, 5'd0, 5'd0, 5'd0, 5'd0, 32'h10), waits);
    send(enc(5'd22, 5'd0, 5'd0, 17'h00020), ex(8'b0010_0000, 5'd0, 5'd0, 5'd0, 5'd0, 32'h20), waits);
    send(enc(5'd31, 5'd1, 5'd2, 17'h1F000), ex(8'b1000_0000, 5'd0, 5'd1, 5'd2, 5'd31, 32'hFFFFF000), waits);
    chk("illegal_valid", 64'(out_valid), 64'd1);

    // flush with a candidate instruction present: nothing captured
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = enc(5'd5, 5'd2, 5'd2, 17'h00001);
    @(negedge clock);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle(1);
    chk("flush_not_captured", 64'(out_valid), 64'd0);

    // reset mid-stream with a held result
    out_ready = 1'b0;
    send(enc(5'd3, 5'd10, 5'd0, 17'h00123), ex(8'b0010_1000, 5'd0, 5'd10, 5'd0, 5'd0, 32'h123), waits);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_outputs", 64'(act), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    send(32'h28C3FFFB, ex(8'b0000_1001, 5'd0, 5'd3, 5'd1, 5'd31, 32'hFFFFFFFB), waits);
    chk("post_reset_latency", 64'(out_valid), 64'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
